multicycle_ctrl: RTL and testbench

- Multi-cycle control FSM for the RV32I datapath; drives the ALU's control inputs (ALUctrl, ALUsrc) and consumes its EQ flag.
- Sequences fetch, decode, execute, memory and writeback steps against handshaked instruction and data memories.
- Generates register-file, memory and PC strobes.
- Keeps a retired-instruction counter.

---
 rtl/multicycle_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback and counts retired instructions.
// Optional macro ILLEGAL_TRAP_EN: illegal instructions trap (sticky) instead of retiring as a NOP.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             EQ,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [2:0]       ALUctrl,
  output logic             ALUsrc,
  output logic [1:0]       ImmSrc,
  output logic             RegWrite,
  output logic             ResultSrc,
  output logic             PCWrite,
  output logic             PCsrc,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired,
  output logic             illegal
);

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC_R   = 4'd2,
    ST_EXEC_I   = 4'd3,
    ST_MEM_ADDR = 4'd4,
    ST_MEM_RD   = 4'd5,
    ST_MEM_WR   = 4'd6,
    ST_WB_ALU   = 4'd7,
    ST_WB_MEM   = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_TRAP     = 4'd10
  } state_t;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  function automatic logic ir_parity(input logic [31:0] w);
    return ^w;
  endfunction

  function automatic logic [2:0] alu_op_f(input logic [2:0] f3, input logic is_r, input logic f7b5);
    logic [2:0] op;
    case (f3)
      3'b000:  op = (is_r && f7b5) ? 3'b001 : 3'b000;
      3'b111:  op = 3'b010;
      3'b110:  op = 3'b011;
      3'b010:  op = 3'b101;
      default: op = 3'b000;
    endcase
    return op;
  endfunction

  state_t           state_q, state_d;
  logic [31:0]      ir_q, ir_d;
  logic             ir_par_q, ir_par_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             illegal_q, illegal_d;

  logic [6:0] opcode_s;
  logic [2:0] f3_s;
  logic       is_r_s, is_i_s, is_lw_s, is_sw_s, is_br_s;
  logic       f3_ok_s, alu_legal_s, ir_perr_s, legal_s;
  logic [2:0] alu_op_s;

  // Decode fields of the latched IR; a parity mismatch marks the IR as corrupted and thus illegal.
  always_comb begin
    opcode_s    = ir_q[6:0];
    f3_s        = ir_q[14:12];
    is_r_s      = (opcode_s == OP_R);
    is_i_s      = (opcode_s == OP_I);
    is_lw_s     = (opcode_s == OP_LD) && (f3_s == 3'b010);
    is_sw_s     = (opcode_s == OP_ST) && (f3_s == 3'b010);
    is_br_s     = (opcode_s == OP_BR) && ((f3_s == 3'b000) || (f3_s == 3'b001));
    f3_ok_s     = (f3_s == 3'b000) || (f3_s == 3'b111) || (f3_s == 3'b110) || (f3_s == 3'b010);
    alu_legal_s = (is_r_s || is_i_s) && f3_ok_s;
    ir_perr_s   = (ir_parity(ir_q) != ir_par_q);
    legal_s     = !ir_perr_s && (alu_legal_s || is_lw_s || is_sw_s || is_br_s);
    alu_op_s    = alu_op_f(f3_s, is_r_s, ir_q[30]);
  end

  // Next-state and Moore outputs (MEM_WR PCWrite and BRANCH PCsrc also look at ready/EQ).
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    ir_par_d  = ir_par_q;
    illegal_d = illegal_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    ALUctrl   = 3'b000;
    ALUsrc    = 1'b0;
    ImmSrc    = 2'b00;
    RegWrite  = 1'b0;
    ResultSrc = 1'b0;
    PCWrite   = 1'b0;
    PCsrc     = 1'b0;
    case (state_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          IRWrite  = 1'b1;
          ir_d     = instr;
          ir_par_d = ir_parity(instr);
          state_d  = ST_DECODE;
        end else begin
          state_d  = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (!legal_s) begin
`ifdef ILLEGAL_TRAP_EN
          state_d   = ST_TRAP;
          illegal_d = 1'b1;
`else
          state_d   = ST_WB_ALU;
`endif
        end else if (is_r_s) begin
          state_d = ST_EXEC_R;
        end else if (is_i_s) begin
          state_d = ST_EXEC_I;
        end else if (is_lw_s || is_sw_s) begin
          state_d = ST_MEM_ADDR;
        end else begin
          state_d = ST_BRANCH;
        end
      end
      ST_EXEC_R: begin
        ALUctrl = alu_op_s;
        state_d = ST_WB_ALU;
      end
      ST_EXEC_I: begin
        ALUctrl = alu_op_s;
        ALUsrc  = 1'b1;
        state_d = ST_WB_ALU;
      end
      ST_WB_ALU: begin
        // Also the NOP step for illegal instructions when trapping is disabled.
        ALUctrl  = alu_legal_s ? alu_op_s : 3'b000;
        ALUsrc   = alu_legal_s ? is_i_s : 1'b0;
        RegWrite = legal_s;
        PCWrite  = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_MEM_ADDR: begin
        ALUsrc  = 1'b1;
        ImmSrc  = is_sw_s ? 2'b01 : 2'b00;
        state_d = is_sw_s ? ST_MEM_WR : ST_MEM_RD;
      end
      ST_MEM_RD: begin
        dmem_req = 1'b1;
        ALUsrc   = 1'b1;
        state_d  = dmem_ready ? ST_WB_MEM : ST_MEM_RD;
      end
      ST_WB_MEM: begin
        RegWrite  = 1'b1;
        ResultSrc = 1'b1;
        PCWrite   = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_MEM_WR: begin
        dmem_req = 1'b1;
        MemWrite = 1'b1;
        ALUsrc   = 1'b1;
        ImmSrc   = 2'b01;
        PCWrite  = dmem_ready;
        state_d  = dmem_ready ? ST_FETCH : ST_MEM_WR;
      end
      ST_BRANCH: begin
        ALUctrl = 3'b001;
        ImmSrc  = 2'b10;
        PCWrite = 1'b1;
        PCsrc   = (f3_s == 3'b000) ? EQ : !EQ;
        state_d = ST_FETCH;
      end
      ST_TRAP: begin
        state_d = ST_TRAP;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // Retire counter advances with every PC update and wraps naturally.
  always_comb begin
    if (PCWrite) begin
      retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      retired_d = retired_q;
    end
  end

  // State, IR and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      ir_q      <= 32'h0000_0000;
      ir_par_q  <= 1'b0;
      retired_q <= {CNT_W{1'b0}};
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      ir_par_q  <= ir_par_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  assign state   = state_q;
  assign retired = retired_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl; covers both builds of ILLEGAL_TRAP_EN.
module tb_multicycle_ctrl;
  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        imem_ready, dmem_ready, EQ;
  logic        imem_req, dmem_req, MemWrite, IRWrite;
  logic [2:0]  ALUctrl;
  logic        ALUsrc;
  logic [1:0]  ImmSrc;
  logic        RegWrite, ResultSrc, PCWrite, PCsrc;
  logic [3:0]  state;
  logic [31:0] retired;
  logic        illegal;

  int n_total = 0;
  int n_pass  = 0;
  int ncyc    = 0;
  int t0;
  logic [31:0] exp_ret = 32'h0;

  multicycle_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .instr(instr), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .EQ(EQ), .imem_req(imem_req), .dmem_req(dmem_req),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ALUctrl(ALUctrl), .ALUsrc(ALUsrc),
    .ImmSrc(ImmSrc), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .PCWrite(PCWrite),
    .PCsrc(PCsrc), .state(state), .retired(retired), .illegal(illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    ncyc++;
  endtask

  // Fetch, decode, execute, writeback for one ALU instruction.
  task automatic run_alu(input logic [31:0] ins, input logic [3:0] st, input logic [2:0] ctl,
                         input logic src);
    instr = ins; imem_ready = 1'b1; #1;
    check("fetch_state", {28'h0, state}, 32'd0);
    check("fetch_irwrite", {31'h0, IRWrite}, 32'd1);
    cyc(); instr = 32'h0;
    check("decode_state", {28'h0, state}, 32'd1);
    cyc();
    check("exec_state", {28'h0, state}, {28'h0, st});
    check("exec_aluctrl", {29'h0, ALUctrl}, {29'h0, ctl});
    check("exec_alusrc", {31'h0, ALUsrc}, {31'h0, src});
    check("exec_immsrc", {30'h0, ImmSrc}, 32'd0);
    check("exec_regwrite", {31'h0, RegWrite}, 32'd0);
    cyc();
    check("wb_state", {28'h0, state}, 32'd7);
    check("wb_aluctrl", {29'h0, ALUctrl}, {29'h0, ctl});
    check("wb_alusrc", {31'h0, ALUsrc}, {31'h0, src});
    check("wb_ctl", {28'h0, RegWrite, ResultSrc, PCWrite, PCsrc}, 32'b1010);
    cyc(); exp_ret++;
    check("retire_state", {28'h0, state}, 32'd0);
    check("retired", retired, exp_ret);
  endtask

  initial begin
    rst = 1'b1; instr = 32'h0; imem_ready = 1'b0; dmem_ready = 1'b1; EQ = 1'b0;
    #3;
    check("rst_state", {28'h0, state}, 32'd0);
    check("rst_imem_req", {31'h0, imem_req}, 32'd1);
    check("rst_strobes", {25'h0, dmem_req, MemWrite, IRWrite, RegWrite, ResultSrc, PCWrite, PCsrc}, 32'd0);
    check("rst_alu", {26'h0, ALUctrl, ALUsrc, ImmSrc}, 32'd0);
    check("rst_retired", retired, 32'd0);
    check("rst_illegal", {31'h0, illegal}, 32'd0);
    cyc(); cyc();
    rst = 1'b0;

    // R-type then I-type ALU ops.
    run_alu(32'h002081B3, 4'd2, 3'b000, 1'b0); // add
    run_alu(32'h402081B3, 4'd2, 3'b001, 1'b0); // sub
    run_alu(32'h0020F1B3, 4'd2, 3'b010, 1'b0); // and
    run_alu(32'h0020E1B3, 4'd2, 3'b011, 1'b0); // or
    run_alu(32'h0020A1B3, 4'd2, 3'b101, 1'b0); // slt
    run_alu(32'h00500093, 4'd3, 3'b000, 1'b1); // addi
    run_alu(32'h0070F093, 4'd3, 3'b010, 1'b1); // andi
    run_alu(32'h0070E093, 4'd3, 3'b011, 1'b1); // ori
    run_alu(32'h0070A093, 4'd3, 3'b101, 1'b1); // slti

    // lw with three wait cycles: 8 cycles total.
    instr = 32'h0040A103; dmem_ready = 1'b0; t0 = ncyc;
    cyc(); instr = 32'h0;
    cyc();
    check("lw_addr_state", {28'h0, state}, 32'd4);
    check("lw_addr_alu", {26'h0, ALUctrl, ALUsrc, ImmSrc}, 32'b000_1_00);
    cyc();
    for (int i = 0; i < 3; i++) begin
      check("lw_rd_state", {28'h0, state}, 32'd5);
      check("lw_rd_req", {29'h0, dmem_req, MemWrite, imem_req}, 32'b100);
      cyc();
    end
    check("lw_rd_last", {28'h0, state}, 32'd5);
    dmem_ready = 1'b1;
    cyc();
    check("lw_wb_state", {28'h0, state}, 32'd8);
    check("lw_wb_ctl", {28'h0, RegWrite, ResultSrc, PCWrite, PCsrc}, 32'b1110);
    cyc(); exp_ret++;
    check("lw_cycles", ncyc - t0, 32'd8);
    check("lw_retired", retired, exp_ret);

    // sw with one wait cycle: PCWrite only once ready.
    instr = 32'h0020A223; dmem_ready = 1'b0;
    cyc(); instr = 32'h0;
    cyc();
    check("sw_addr_immsrc", {30'h0, ImmSrc}, 32'd1);
    cyc();
    check("sw_wr_state", {28'h0, state}, 32'd6);
    check("sw_wr_req", {29'h0, dmem_req, MemWrite, PCWrite}, 32'b110);
    dmem_ready = 1'b1; #1;
    check("sw_wr_pcwrite", {30'h0, PCWrite, PCsrc}, 32'b10);
    cyc(); exp_ret++;
    check("sw_state", {28'h0, state}, 32'd0);
    check("sw_retired", retired, exp_ret);

    // beq then bne; EQ is combinational in BRANCH.
    instr = 32'h00208463;
    cyc(); instr = 32'h0;
    cyc();
    check("beq_state", {28'h0, state}, 32'd9);
    check("beq_alu", {26'h0, ALUctrl, ALUsrc, ImmSrc}, 32'b001_0_10);
    EQ = 1'b1; #1;
    check("beq_eq1", {30'h0, PCWrite, PCsrc}, 32'b11);
    EQ = 1'b0; #1;
    check("beq_eq0", {30'h0, PCWrite, PCsrc}, 32'b10);
    cyc(); exp_ret++;
    instr = 32'h00209463;
    cyc(); instr = 32'h0;
    cyc();
    check("bne_state", {28'h0, state}, 32'd9);
    check("bne_eq0", {31'h0, PCsrc}, 32'd1);
    EQ = 1'b1; #1;
    check("bne_eq1", {31'h0, PCsrc}, 32'd0);
    cyc(); exp_ret++; EQ = 1'b0;
    check("br_retired", retired, exp_ret);

    // Illegal instruction.
    instr = 32'hFFFFFFFF;
    cyc(); instr = 32'h0;
    cyc();
`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 20; i++) begin
      check("trap_state", {28'h0, state}, 32'd10);
      check("trap_flags", {29'h0, illegal, imem_req, PCWrite}, 32'b100);
      cyc();
    end
    check("trap_retired", retired, exp_ret);
    rst = 1'b1; #1;
    check("trap_rst_state", {28'h0, state}, 32'd0);
    check("trap_rst_illegal", {31'h0, illegal}, 32'd0);
    cyc(); rst = 1'b0; exp_ret = 32'h0;
`else
    check("nop_state", {28'h0, state}, 32'd7);
    check("nop_ctl", {28'h0, RegWrite, ResultSrc, PCWrite, PCsrc}, 32'b0010);
    cyc(); exp_ret++;
    check("nop_fetch", {28'h0, state}, 32'd0);
    check("nop_retired", retired, exp_ret);
    check("nop_illegal", {31'h0, illegal}, 32'd0);
`endif

    // Asynchronous reset in the middle of a load.
    instr = 32'h0040A103; imem_ready = 1'b1; dmem_ready = 1'b0;
    cyc(); instr = 32'h0;
    cyc(); cyc();
    check("mrd_req", {31'h0, dmem_req}, 32'd1);
    rst = 1'b1; #1;
    check("mrd_rst_state", {28'h0, state}, 32'd0);
    check("mrd_rst_req", {30'h0, dmem_req, imem_req}, 32'b01);
    check("mrd_rst_retired", retired, 32'd0);
    cyc(); imem_ready = 1'b0; dmem_ready = 1'b1;
    cyc(); rst = 1'b0;

    // Counter wrap from all-ones.
    force dut.retired_q = 32'hFFFFFFFF;
    cyc();
    release dut.retired_q;
    #1;
    check("wrap_preload", retired, 32'hFFFFFFFF);
    exp_ret = 32'hFFFFFFFF;
    run_alu(32'h002081B3, 4'd2, 3'b000, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
